// File: rtl/rv_pkg.sv
// Shared constants and types for the integer register-file write-back path.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: marks destinations pending at issue, clears them on write-back.
module reg_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_dest,
    input  logic [REG_AW-1:0] chk_addr_1,
    input  logic [REG_AW-1:0] chk_addr_2,
    output logic              chk_busy_1,
    output logic              chk_busy_2,
    output logic [REG_AW:0]   busy_cnt
);

    localparam int NREG = 2 ** REG_AW;

    logic [NREG-1:0] busy_q, busy_d;
    logic [REG_AW:0] cnt_q, cnt_d;
    logic            set_v, clr_v, inc, dec;

    always_comb begin
        set_v  = issue_en && (issue_dest != '0);
        clr_v  = wr_en && (wr_dest != '0);
        busy_d = busy_q;
        if (clr_v) begin
            busy_d[wr_dest] = 1'b0;
        end
        // Set is applied after clear: a newly issued producer outranks the retiring one.
        if (set_v) begin
            busy_d[issue_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;
        inc   = set_v && !busy_q[issue_dest];
        dec   = clr_v && busy_q[wr_dest] && !(set_v && (issue_dest == wr_dest));
        cnt_d = cnt_q + (REG_AW+1)'(inc) - (REG_AW+1)'(dec);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign chk_busy_1 = busy_q[chk_addr_1];
    assign chk_busy_2 = busy_q[chk_addr_2];
    assign busy_cnt   = cnt_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Round-robin arbiter for the register-file write port (ALU vs. LSU) with a
// registered write stage and a busy scoreboard for issue-stage stalls.
module regfile_wb_ctrl #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_dest,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_dest,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              issue_en,
    input  logic [REG_AW-1:0] issue_dest,
    input  logic [REG_AW-1:0] chk_addr_1,
    input  logic [REG_AW-1:0] chk_addr_2,
    output logic              chk_busy_1,
    output logic              chk_busy_2,
    output logic [5:0]        busy_cnt,
    output logic              reg_write_en,
    output logic [REG_AW-1:0] reg_write_dest,
    output logic [XLEN-1:0]   reg_write_data
);

    import rv_pkg::*;

    grant_e            last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_dest_q, wr_dest_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;
    logic [REG_AW:0]   cnt;

    // On a tie, the side that did not win the previous accept gets the port.
    always_comb begin
        alu_ready    = alu_valid && (!lsu_valid || (last_grant_q == GNT_LSU));
        lsu_ready    = lsu_valid && (!alu_valid || (last_grant_q == GNT_ALU));
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_dest_d    = wr_dest_q;
        wr_data_d    = wr_data_q;
        if (alu_ready) begin
            last_grant_d = GNT_ALU;
            wr_dest_d    = alu_dest;
            wr_data_d    = alu_data;
            wr_en_d      = (alu_dest != '0);
        end else if (lsu_ready) begin
            last_grant_d = GNT_LSU;
            wr_dest_d    = lsu_dest;
            wr_data_d    = lsu_data;
            wr_en_d      = (lsu_dest != '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GNT_LSU;
            wr_en_q      <= 1'b0;
            wr_dest_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_dest_q    <= wr_dest_d;
            wr_data_q    <= wr_data_d;
        end
    end

    reg_scoreboard #(
        .REG_AW(REG_AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_en   (issue_en),
        .issue_dest (issue_dest),
        .wr_en      (wr_en_q),
        .wr_dest    (wr_dest_q),
        .chk_addr_1 (chk_addr_1),
        .chk_addr_2 (chk_addr_2),
        .chk_busy_1 (chk_busy_1),
        .chk_busy_2 (chk_busy_2),
        .busy_cnt   (cnt)
    );

    assign busy_cnt       = 6'(cnt);
    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;

endmodule
